offset_sweep_ctrl: RTL and testbench

Sequencer that drives the `i_offset` input of the `gen_mask` block across a programmed offset range and presents each resulting mask to the downstream comparator with a valid/ready handshake. It accounts for the one-cycle registered latency of `gen_mask`. It also collects the comparator's per-mask match flag into a summary: found flag, lowest matching offset and match count. It sits between the host/config registers and the mask/compare datapath of the search engine.

---
 rtl/offset_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_offset_sweep_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/offset_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// offset_sweep_ctrl
//
// Walks the i_offset input of an attached gen_mask block across a programmed,
// inclusive offset range and presents each registered mask to the downstream
// comparator with a valid/ready handshake. Also folds the comparator's
// per-mask match flag into a summary (found flag, lowest matching offset,
// match count).
//
// Ports
//   clk             : clock, all logic on posedge
//   rst             : synchronous active-high reset
//   i_start         : start pulse, accepted only in IDLE
//   i_first_offset  : first offset of the sweep, sampled on accepted start
//   i_last_offset   : last offset (inclusive), sampled on accepted start
//   o_offset        : drives gen_mask.i_offset
//   o_mask_valid    : gen_mask.o_mask corresponds to o_offset
//   i_mask_ready    : comparator accepts the current mask
//   i_match         : comparator result, used only on handshake
//   o_busy          : controller is not idle
//   o_done          : one-cycle pulse at sweep end
//   o_match_found   : at least one handshake reported a match
//   o_match_offset  : offset of the first (lowest) match, 0 if none
//   o_match_count   : number of matching handshakes (saturating)
// -----------------------------------------------------------------------------
// state   | meaning
// --------+--------------------------------------------------------------------
// IDLE    | waiting for i_start; results hold from the previous sweep
// LOAD    | o_offset just changed; gen_mask registers the new mask this cycle
// ISSUE   | mask valid, waiting for the comparator handshake
// DONE    | sweep finished, o_done pulses for this single cycle
// -----------------------------------------------------------------------------
module offset_sweep_ctrl #(
   parameter int SEQ_WIDTH = 40,
   parameter int OFFSET_W  = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic [OFFSET_W-1:0] i_first_offset,
   input  logic [OFFSET_W-1:0] i_last_offset,
   output logic [OFFSET_W-1:0] o_offset,
   output logic                o_mask_valid,
   input  logic                i_mask_ready,
   input  logic                i_match,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_match_found,
   output logic [OFFSET_W-1:0] o_match_offset,
   output logic [OFFSET_W-1:0] o_match_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ISSUE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Offset SEQ_WIDTH itself is the first all-zero mask; sweeping past it
   // would only repeat identical all-zero beats.
   localparam logic [OFFSET_W-1:0] LAST_MAX = OFFSET_W'(SEQ_WIDTH);
   localparam logic [OFFSET_W-1:0] CNT_MAX  = '1;
   localparam logic [OFFSET_W-1:0] ONE      = OFFSET_W'(1);

   state_t              state_q, state_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;
   logic [OFFSET_W-1:0] last_q, last_d;
   logic                found_q, found_d;
   logic [OFFSET_W-1:0] moff_q, moff_d;
   logic [OFFSET_W-1:0] count_q, count_d;

   logic [OFFSET_W-1:0] last_clamped;

   assign last_clamped = (i_last_offset > LAST_MAX) ? LAST_MAX : i_last_offset;

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      last_d   = last_q;
      found_d  = found_q;
      moff_d   = moff_q;
      count_d  = count_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               last_d  = last_clamped;
               found_d = 1'b0;
               moff_d  = '0;
               count_d = '0;
               if (i_first_offset > last_clamped) begin
                  state_d = S_DONE;
               end else begin
                  offset_d = i_first_offset;
                  state_d  = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            state_d = S_ISSUE;
         end

         S_ISSUE: begin
            if (i_mask_ready) begin
               if (i_match) begin
                  if (count_q != CNT_MAX) begin
                     count_d = count_q + ONE;
                  end
                  // Offsets only ascend, so the first match is the lowest.
                  if (!found_q) begin
                     found_d = 1'b1;
                     moff_d  = offset_q;
                  end
               end
               if (offset_q == last_q) begin
                  state_d = S_DONE;
               end else begin
                  // Cannot wrap: last_q <= SEQ_WIDTH < 2**OFFSET_W.
                  offset_d = offset_q + ONE;
                  state_d  = S_LOAD;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         offset_q <= '0;
         last_q   <= '0;
         found_q  <= 1'b0;
         moff_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         last_q   <= last_d;
         found_q  <= found_d;
         moff_q   <= moff_d;
         count_q  <= count_d;
      end
   end

   // Handshake-side outputs are decoded from the state register only, so
   // nothing combinational reaches them from i_mask_ready or i_match.
   assign o_offset       = offset_q;
   assign o_mask_valid   = (state_q == S_ISSUE);
   assign o_busy         = (state_q != S_IDLE);
   assign o_done         = (state_q == S_DONE);
   assign o_match_found  = found_q;
   assign o_match_offset = moff_q;
   assign o_match_count  = count_q;

endmodule

// File: tb/tb_offset_sweep_ctrl.sv
module tb_offset_sweep_ctrl;

   localparam int SW = 40;
   localparam int OW = 7;

   logic          clk;
   logic          rst;
   logic          i_start;
   logic [OW-1:0] i_first_offset;
   logic [OW-1:0] i_last_offset;
   logic [OW-1:0] o_offset;
   logic          o_mask_valid;
   logic          i_mask_ready;
   logic          i_match;
   logic          o_busy;
   logic          o_done;
   logic          o_match_found;
   logic [OW-1:0] o_match_offset;
   logic [OW-1:0] o_match_count;

   int checks   = 0;
   int failures = 0;

   bit match_en [128];
   localparam logic [SW-1:0] ALL1 = '1;
   logic [SW-1:0] mask_q;

   int            hs_off  [$];
   logic [SW-1:0] hs_mask [$];
   int            vlog    [$];

   offset_sweep_ctrl #(.SEQ_WIDTH(SW), .OFFSET_W(OW)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (i_start),
      .i_first_offset (i_first_offset),
      .i_last_offset  (i_last_offset),
      .o_offset       (o_offset),
      .o_mask_valid   (o_mask_valid),
      .i_mask_ready   (i_mask_ready),
      .i_match        (i_match),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_match_found  (o_match_found),
      .o_match_offset (o_match_offset),
      .o_match_count  (o_match_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural gen_mask: one-cycle registered, all ones shifted right by offset.
   always @(posedge clk)
      mask_q <= (int'(o_offset) >= SW) ? '0 : (ALL1 >> o_offset);

   assign i_match = match_en[o_offset];

   always @(posedge clk) begin
      if (!rst && o_mask_valid) begin
         vlog.push_back(int'(o_offset));
         if (i_mask_ready) begin
            hs_off.push_back(int'(o_offset));
            hs_mask.push_back(mask_q);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_matches();
      for (int i = 0; i < 128; i++) match_en[i] = 1'b0;
   endtask

   // Starts a sweep from the current cycle; done_at is the cycle (E+k) in
   // which o_done is seen, -1 if the bound expires.
   task automatic run_sweep(input int first, input int last, input int stall,
                            input int poke_k, output int done_at);
      int stall_left;
      stall_left     = stall;
      i_first_offset = OW'(first);
      i_last_offset  = OW'(last);
      i_mask_ready   = 1'b1;
      i_start        = 1'b1;
      tick();
      i_start = 1'b0;
      done_at = -1;
      for (int k = 1; k <= 300; k++) begin
         if (o_done) begin
            done_at = k;
            break;
         end
         i_start = (k == poke_k);
         if (k == poke_k) begin
            i_first_offset = 7'd20;
            i_last_offset  = 7'd25;
         end
         if (o_mask_valid && stall_left > 0) begin
            i_mask_ready = 1'b0;
            stall_left--;
         end else begin
            i_mask_ready = 1'b1;
         end
         tick();
      end
      i_start      = 1'b0;
      i_mask_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_start = 1'b0;
      i_first_offset = '0;
      i_last_offset = '0;
      i_mask_ready = 1'b1;
      clear_matches();
      repeat (3) tick();
      checks++;
      if ({o_offset, o_mask_valid, o_busy, o_done, o_match_found, o_match_offset, o_match_count} !== '0) begin
         failures++;
         $display("FAIL reset: off=%0d v=%0b busy=%0b done=%0b found=%0b moff=%0d cnt=%0d, want all 0",
                  o_offset, o_mask_valid, o_busy, o_done, o_match_found, o_match_offset, o_match_count);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int base, done_at;
      logic [SW-1:0] exp_m [4] = '{40'hFF_FFFF_FFFF, 40'h7F_FFFF_FFFF,
                                   40'h3F_FFFF_FFFF, 40'h1F_FFFF_FFFF};
      clear_matches();
      match_en[2] = 1'b1;
      base = hs_off.size();
      run_sweep(0, 3, 0, 0, done_at);
      checks++;
      if (done_at !== 9) begin failures++; $display("FAIL basic_done_at: got %0d want 9", done_at); end
      checks++;
      if (hs_off.size() - base !== 4) begin
         failures++; $display("FAIL basic_beats: got %0d want 4", hs_off.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (hs_off[base+i] !== i) begin
               failures++; $display("FAIL basic_off[%0d]: got %0d want %0d", i, hs_off[base+i], i);
            end
            checks++;
            if (hs_mask[base+i] !== exp_m[i]) begin
               failures++; $display("FAIL basic_mask[%0d]: got %h want %h", i, hs_mask[base+i], exp_m[i]);
            end
         end
      end
      checks++;
      if ({o_match_found, o_match_offset, o_match_count} !== {1'b1, 7'd2, 7'd1}) begin
         failures++;
         $display("FAIL basic_result: found=%0b moff=%0d cnt=%0d want 1/2/1", o_match_found, o_match_offset, o_match_count);
      end
      tick();
      checks++;
      if ({o_done, o_busy} !== 2'b00) begin
         failures++; $display("FAIL basic_after_done: done=%0b busy=%0b want 0/0", o_done, o_busy);
      end
   endtask

   task automatic test_backpressure();
      int base, vbase, done_at;
      int exp_v [5] = '{5, 5, 5, 5, 6};
      clear_matches();
      base  = hs_off.size();
      vbase = vlog.size();
      run_sweep(5, 6, 3, 0, done_at);
      checks++;
      if (done_at !== 8) begin failures++; $display("FAIL bp_done_at: got %0d want 8", done_at); end
      checks++;
      if (vlog.size() - vbase !== 5) begin
         failures++; $display("FAIL bp_valid_cycles: got %0d want 5", vlog.size() - vbase);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (vlog[vbase+i] !== exp_v[i]) begin
               failures++; $display("FAIL bp_valid_off[%0d]: got %0d want %0d", i, vlog[vbase+i], exp_v[i]);
            end
         end
      end
      checks++;
      if (hs_off.size() - base !== 2 || hs_off[base] !== 5 || hs_off[base+1] !== 6) begin
         failures++; $display("FAIL bp_handshakes: count %0d want 2 at 5,6", hs_off.size() - base);
      end
      checks++;
      if ({o_match_found, o_match_offset, o_match_count} !== '0) begin
         failures++;
         $display("FAIL bp_result: found=%0b moff=%0d cnt=%0d want 0/0/0", o_match_found, o_match_offset, o_match_count);
      end
      tick();
   endtask

   task automatic test_clamp();
      int base, done_at;
      int exp_o [3] = '{38, 39, 40};
      logic [SW-1:0] exp_m [3] = '{40'h3, 40'h1, 40'h0};
      clear_matches();
      match_en[40] = 1'b1;
      base = hs_off.size();
      run_sweep(38, 100, 0, 0, done_at);
      checks++;
      if (done_at !== 7) begin failures++; $display("FAIL clamp_done_at: got %0d want 7", done_at); end
      checks++;
      if (hs_off.size() - base !== 3) begin
         failures++; $display("FAIL clamp_beats: got %0d want 3", hs_off.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (hs_off[base+i] !== exp_o[i] || hs_mask[base+i] !== exp_m[i]) begin
               failures++;
               $display("FAIL clamp_beat[%0d]: off=%0d mask=%h want off=%0d mask=%h",
                        i, hs_off[base+i], hs_mask[base+i], exp_o[i], exp_m[i]);
            end
         end
      end
      checks++;
      if ({o_match_found, o_match_offset, o_match_count} !== {1'b1, 7'd40, 7'd1}) begin
         failures++;
         $display("FAIL clamp_result: found=%0b moff=%0d cnt=%0d want 1/40/1", o_match_found, o_match_offset, o_match_count);
      end
      tick();
   endtask

   task automatic test_empty();
      int base, done_at;
      clear_matches();
      base = hs_off.size();
      run_sweep(10, 4, 0, 0, done_at);
      checks++;
      if (done_at !== 1) begin failures++; $display("FAIL empty_done_at: got %0d want 1", done_at); end
      checks++;
      if (o_busy !== 1'b1) begin failures++; $display("FAIL empty_busy_in_done: got %0b want 1", o_busy); end
      checks++;
      if (hs_off.size() - base !== 0) begin
         failures++; $display("FAIL empty_beats: got %0d want 0", hs_off.size() - base);
      end
      checks++;
      if ({o_match_found, o_match_offset, o_match_count} !== '0) begin
         failures++;
         $display("FAIL empty_result: found=%0b moff=%0d cnt=%0d want 0/0/0", o_match_found, o_match_offset, o_match_count);
      end
      tick();
   endtask

   task automatic test_multi();
      int done_at;
      clear_matches();
      match_en[7]  = 1'b1;
      match_en[20] = 1'b1;
      match_en[39] = 1'b1;
      run_sweep(0, 39, 0, 0, done_at);
      checks++;
      if (done_at !== 81) begin failures++; $display("FAIL multi_done_at: got %0d want 81", done_at); end
      checks++;
      if ({o_match_found, o_match_offset, o_match_count} !== {1'b1, 7'd7, 7'd3}) begin
         failures++;
         $display("FAIL multi_result: found=%0b moff=%0d cnt=%0d want 1/7/3", o_match_found, o_match_offset, o_match_count);
      end
      clear_matches();
      repeat (6) tick();
      checks++;
      if ({o_busy, o_match_found, o_match_offset, o_match_count} !== {1'b0, 1'b1, 7'd7, 7'd3}) begin
         failures++;
         $display("FAIL multi_hold: busy=%0b found=%0b moff=%0d cnt=%0d want 0/1/7/3",
                  o_busy, o_match_found, o_match_offset, o_match_count);
      end
   endtask

   task automatic test_start_busy();
      int base, done_at;
      clear_matches();
      match_en[2]  = 1'b1;
      match_en[22] = 1'b1;
      base = hs_off.size();
      run_sweep(0, 3, 0, 3, done_at);
      checks++;
      if (done_at !== 9) begin failures++; $display("FAIL busy_start_done_at: got %0d want 9", done_at); end
      checks++;
      if (hs_off.size() - base !== 4 || hs_off[base] !== 0 || hs_off[base+3] !== 3) begin
         failures++; $display("FAIL busy_start_beats: count %0d want 4 covering 0..3", hs_off.size() - base);
      end
      checks++;
      if ({o_match_found, o_match_offset, o_match_count} !== {1'b1, 7'd2, 7'd1}) begin
         failures++;
         $display("FAIL busy_start_result: found=%0b moff=%0d cnt=%0d want 1/2/1", o_match_found, o_match_offset, o_match_count);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int done_a, done_b;
      clear_matches();
      match_en[4] = 1'b1;
      run_sweep(3, 3, 0, 0, done_a);
      tick();
      checks++;
      if (o_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy: got %0b want 0", o_busy); end
      run_sweep(4, 4, 0, 0, done_b);
      checks++;
      if (done_a !== 3 || done_b !== 3) begin
         failures++; $display("FAIL b2b_done_at: got %0d,%0d want 3,3", done_a, done_b);
      end
      checks++;
      if ({o_match_found, o_match_offset, o_match_count} !== {1'b1, 7'd4, 7'd1}) begin
         failures++;
         $display("FAIL b2b_result: found=%0b moff=%0d cnt=%0d want 1/4/1", o_match_found, o_match_offset, o_match_count);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int done_at, n;
      bit seen_done;
      clear_matches();
      match_en[0] = 1'b1;
      i_first_offset = 7'd0;
      i_last_offset  = 7'd5;
      i_mask_ready   = 1'b1;
      i_start        = 1'b1;
      tick();
      i_start = 1'b0;
      n = 0;
      while (!(o_mask_valid && o_offset == 7'd2) && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin failures++; $display("FAIL rstmid_reach_issue2: timeout after %0d cycles", n); end
      rst = 1'b1;
      tick();
      checks++;
      if ({o_offset, o_mask_valid, o_busy, o_done, o_match_found, o_match_offset, o_match_count} !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs: off=%0d v=%0b busy=%0b done=%0b found=%0b moff=%0d cnt=%0d want all 0",
                  o_offset, o_mask_valid, o_busy, o_done, o_match_found, o_match_offset, o_match_count);
      end
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_done) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done: got done pulse, want none"); end
      clear_matches();
      match_en[1] = 1'b1;
      run_sweep(1, 2, 0, 0, done_at);
      checks++;
      if (done_at !== 5 || {o_match_found, o_match_offset, o_match_count} !== {1'b1, 7'd1, 7'd1}) begin
         failures++;
         $display("FAIL rstmid_rerun: done_at=%0d found=%0b moff=%0d cnt=%0d want 5/1/1/1",
                  done_at, o_match_found, o_match_offset, o_match_count);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_clamp();
      test_empty();
      test_multi();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
